fpu_ss_issue_ctrl: RTL and testbench

In-order issue controller between the FPU subsystem decoder and its two execution resources: the FPnew core and the load/store path. It holds one decoded instruction at a time, checks FP register hazards against a 32-entry scoreboard, and issues the instruction to either the FPU or memory. It tracks outstanding FPU operations by tag so that out-of-order FPU completions return the correct destination register for writeback.

---
 rtl/fpu_ss_issue_ctrl.sv | 138 +++++++++++++
 tb/tb_fpu_ss_issue_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fpu_ss_issue_ctrl.sv
// In-order issue controller for the FPU subsystem: holds one decoded instruction,
// checks FPR hazards against a scoreboard and issues it to the FPU or the load/store path.
module fpu_ss_issue_ctrl #(
    parameter  int NumTags = 4,
    localparam int TagW    = (NumTags > 1) ? $clog2(NumTags) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [4:0]      in_rs1_i,
    input  logic [4:0]      in_rs2_i,
    input  logic [4:0]      in_rs3_i,
    input  logic [4:0]      in_rd_i,
    input  logic [2:0]      in_rs_used_i,
    input  logic            in_rd_is_fp_i,
    input  logic            in_use_fpu_i,
    input  logic            in_is_load_i,
    input  logic            in_is_store_i,
    input  logic            fence_i,
    output logic            fpu_valid_o,
    input  logic            fpu_ready_i,
    output logic [TagW-1:0] fpu_tag_o,
    input  logic            fpu_out_valid_i,
    input  logic [TagW-1:0] fpu_out_tag_i,
    output logic            mem_valid_o,
    input  logic            mem_ready_i,
    input  logic            mem_rsp_valid_i,
    output logic            wb_valid_o,
    output logic [4:0]      wb_rd_o,
    output logic            wb_from_mem_o,
    output logic            busy_o
);

    typedef enum logic {RUN, DRAIN} state_e;

    state_e                      state_q, state_d;
    logic [31:0]                 sb_q, sb_d;
    logic [NumTags-1:0]          tag_busy_q;
    logic [NumTags-1:0][4:0]     tag_rd_q;
    logic [NumTags-1:0]          tag_fp_q;
    logic                        ld_pend_q;
    logic [4:0]                  ld_rd_q;

    logic            drain, tag_avail, raw, waw;
    logic [TagW-1:0] free_tag;
    logic            sel_fpu, sel_mem, sel_other, mem_hazard;
    logic            fpu_fire, ld_fire, fpu_cpl, fpu_wb, ld_cpl;

    assign drain = (state_q == DRAIN);

    // Lowest free tag wins: scan downward so the last hit is the smallest index.
    always_comb begin
        free_tag  = '0;
        tag_avail = 1'b0;
        for (int i = NumTags - 1; i >= 0; i--) begin
            if (!tag_busy_q[i]) begin
                free_tag  = TagW'(i);
                tag_avail = 1'b1;
            end
        end
    end

    assign raw = |(in_rs_used_i & {sb_q[in_rs3_i], sb_q[in_rs2_i], sb_q[in_rs1_i]});
    assign waw = in_rd_is_fp_i & sb_q[in_rd_i];

    assign sel_fpu   = in_use_fpu_i;
    assign sel_mem   = !in_use_fpu_i & (in_is_load_i | in_is_store_i);
    assign sel_other = !in_use_fpu_i & !in_is_load_i & !in_is_store_i;

    // Stores only read rs2 and never write the FPR, so they skip RAW on rs1/rs3 and WAW.
    assign mem_hazard = drain | ld_pend_q |
                        (in_is_load_i ? (raw | waw) : sb_q[in_rs2_i]);

    assign fpu_valid_o = !rst_i & in_valid_i & sel_fpu & !(raw | waw | !tag_avail | drain);
    assign mem_valid_o = !rst_i & in_valid_i & sel_mem & !mem_hazard;
    assign fpu_tag_o   = free_tag;
    assign in_ready_o  = (fpu_valid_o & fpu_ready_i) | (mem_valid_o & mem_ready_i) |
                         (!rst_i & sel_other & !drain);

    assign fpu_fire = fpu_valid_o & fpu_ready_i;
    assign ld_fire  = mem_valid_o & mem_ready_i & in_is_load_i;

    // FPU writeback wins the port; the load response is held until a free cycle.
    assign fpu_cpl = fpu_out_valid_i & tag_busy_q[fpu_out_tag_i];
    assign fpu_wb  = fpu_cpl & tag_fp_q[fpu_out_tag_i];
    assign ld_cpl  = mem_rsp_valid_i & ld_pend_q & !fpu_wb;

    assign wb_valid_o    = !rst_i & (fpu_wb | ld_cpl);
    assign wb_rd_o       = fpu_wb ? tag_rd_q[fpu_out_tag_i] : ld_rd_q;
    assign wb_from_mem_o = !fpu_wb & ld_cpl;
    assign busy_o        = !rst_i & ((|tag_busy_q) | ld_pend_q | drain);

    always_comb begin
        sb_d = sb_q;
        if (fpu_wb)                   sb_d[tag_rd_q[fpu_out_tag_i]] = 1'b0;
        if (ld_cpl)                   sb_d[ld_rd_q]                 = 1'b0;
        if (fpu_fire & in_rd_is_fp_i) sb_d[in_rd_i]                 = 1'b1;
        if (ld_fire)                  sb_d[in_rd_i]                 = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (fence_i && !in_valid_i) state_d = DRAIN;
            DRAIN:   if (!(|tag_busy_q) && !ld_pend_q && !fence_i) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            sb_q       <= '0;
            tag_busy_q <= '0;
            tag_rd_q   <= '0;
            tag_fp_q   <= '0;
            ld_pend_q  <= 1'b0;
            ld_rd_q    <= '0;
        end else begin
            state_q <= state_d;
            sb_q    <= sb_d;
            if (fpu_cpl) tag_busy_q[fpu_out_tag_i] <= 1'b0;
            if (fpu_fire) begin
                tag_busy_q[free_tag] <= 1'b1;
                tag_rd_q[free_tag]   <= in_rd_i;
                tag_fp_q[free_tag]   <= in_rd_is_fp_i;
            end
            if (ld_cpl) begin
                ld_pend_q <= 1'b0;
            end else if (ld_fire) begin
                ld_pend_q <= 1'b1;
                ld_rd_q   <= in_rd_i;
            end
        end
    end

endmodule

// File: tb/tb_fpu_ss_issue_ctrl.sv
// Directed bench for fpu_ss_issue_ctrl; writebacks are checked against a queue of
// expected {from_mem, rd} entries pushed whenever a completion is driven.
module tb_fpu_ss_issue_ctrl;
    localparam int NumTags = 4;
    localparam int TagW    = 2;

    logic            clk = 1'b0, rst;
    logic            in_valid, in_ready;
    logic [4:0]      rs1, rs2, rs3, rd;
    logic [2:0]      rs_used;
    logic            rd_is_fp, use_fpu, is_load, is_store, fence;
    logic            fpu_valid, fpu_ready;
    logic [TagW-1:0] fpu_tag, fpu_out_tag;
    logic            fpu_out_valid;
    logic            mem_valid, mem_ready, mem_rsp_valid;
    logic            wb_valid, wb_from_mem, busy;
    logic [4:0]      wb_rd;

    int errors = 0;
    int checks = 0;
    logic [5:0] exp_q[$];

    fpu_ss_issue_ctrl #(.NumTags(NumTags)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_rs1_i(rs1), .in_rs2_i(rs2), .in_rs3_i(rs3), .in_rd_i(rd),
        .in_rs_used_i(rs_used), .in_rd_is_fp_i(rd_is_fp), .in_use_fpu_i(use_fpu),
        .in_is_load_i(is_load), .in_is_store_i(is_store), .fence_i(fence),
        .fpu_valid_o(fpu_valid), .fpu_ready_i(fpu_ready), .fpu_tag_o(fpu_tag),
        .fpu_out_valid_i(fpu_out_valid), .fpu_out_tag_i(fpu_out_tag),
        .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_rsp_valid_i(mem_rsp_valid),
        .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_from_mem_o(wb_from_mem), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic ins(input bit f, input bit ld, input bit st, input logic [4:0] d,
                       input bit dfp, input logic [4:0] a, input logic [4:0] b,
                       input logic [2:0] used);
        in_valid = 1'b1; use_fpu = f; is_load = ld; is_store = st;
        rd = d; rd_is_fp = dfp; rs1 = a; rs2 = b; rs3 = 5'd0; rs_used = used;
    endtask

    task automatic idle();
        in_valid = 1'b0; use_fpu = 1'b0; is_load = 1'b0; is_store = 1'b0;
    endtask

    task automatic cpl(input int t, input logic [4:0] r, input bit fp);
        fpu_out_valid = 1'b1; fpu_out_tag = TagW'(t);
        if (fp) exp_q.push_back({1'b0, r});
    endtask

    // Writeback monitor: every write must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            if (exp_q.size() == 0) chk("wb_unexpected", wb_valid, 0);
            else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                chk("wb_rd", wb_rd, e[4:0]);
                chk("wb_from_mem", wb_from_mem, e[5]);
            end
        end
    end

    initial begin
        rst = 1'b1; fence = 1'b0; fpu_ready = 1'b0; mem_ready = 1'b1;
        fpu_out_valid = 1'b0; fpu_out_tag = '0; mem_rsp_valid = 1'b0;
        ins(1, 0, 0, 5'd3, 1, 5'd1, 5'd2, 3'b011);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_fpu_valid", fpu_valid, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_busy", busy, 0);
        cyc(); rst = 1'b0;
        @(negedge clk);
        chk("post_rst_fpu_valid", fpu_valid, 1);
        chk("post_rst_tag", fpu_tag, 0);
        chk("post_rst_ready_held", in_ready, 0);

        // RAW stall on f5 until its producer completes
        cyc(); fpu_ready = 1'b1; ins(1, 0, 0, 5'd5, 1, 5'd0, 5'd0, 3'b000);
        @(negedge clk);
        chk("fmul_tag", fpu_tag, 0);
        chk("fmul_ready", in_ready, 1);
        cyc(); ins(1, 0, 0, 5'd6, 1, 5'd5, 5'd0, 3'b001);
        @(negedge clk); chk("raw_stall", in_ready, 0);
        cyc(); cpl(0, 5'd5, 1);
        @(negedge clk); chk("raw_cpl_cycle", in_ready, 0);
        cyc(); fpu_out_valid = 1'b0;
        @(negedge clk);
        chk("raw_release", in_ready, 1);
        chk("raw_release_tag", fpu_tag, 0);
        cyc(); idle(); cpl(0, 5'd6, 1);
        cyc(); fpu_out_valid = 1'b0;

        // Tag exhaustion and reuse of the freed tag
        for (int i = 0; i < 4; i++) begin
            ins(1, 0, 0, 5'(10 + i), 1, 5'd0, 5'd0, 3'b000);
            @(negedge clk);
            chk("alloc_tag", fpu_tag, i);
            chk("alloc_ready", in_ready, 1);
            cyc();
        end
        ins(1, 0, 0, 5'd14, 1, 5'd0, 5'd0, 3'b000);
        @(negedge clk); chk("tags_full", in_ready, 0);
        cyc(); cpl(2, 5'd12, 1);
        @(negedge clk); chk("tag_free_same_cycle", in_ready, 0);
        cyc(); fpu_out_valid = 1'b0;
        @(negedge clk);
        chk("reuse_tag", fpu_tag, 2);
        chk("reuse_ready", in_ready, 1);
        cyc(); idle();
        cpl(0, 5'd10, 1); cyc();
        cpl(1, 5'd11, 1); cyc();
        cpl(2, 5'd14, 1); cyc();
        cpl(3, 5'd13, 1); cyc();
        fpu_out_valid = 1'b0;

        // Load-use on a store, plus FPU/load writeback collision
        ins(1, 0, 0, 5'd20, 1, 5'd0, 5'd0, 3'b000);
        @(negedge clk); chk("pre_load_tag", fpu_tag, 0);
        cyc(); ins(0, 1, 0, 5'd7, 1, 5'd1, 5'd0, 3'b001);
        @(negedge clk);
        chk("load_mem_valid", mem_valid, 1);
        chk("load_fpu_valid", fpu_valid, 0);
        chk("load_ready", in_ready, 1);
        cyc(); ins(0, 0, 1, 5'd0, 0, 5'd1, 5'd7, 3'b010);
        @(negedge clk);
        chk("store_stall_ready", in_ready, 0);
        chk("store_stall_valid", mem_valid, 0);
        cyc(); cpl(0, 5'd20, 1); mem_rsp_valid = 1'b1;
        @(negedge clk); chk("store_stall_collide", in_ready, 0);
        cyc(); fpu_out_valid = 1'b0; exp_q.push_back({1'b1, 5'd7});
        @(negedge clk); chk("store_stall_ldrsp", in_ready, 0);
        cyc(); mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("store_issue_valid", mem_valid, 1);
        chk("store_issue_ready", in_ready, 1);
        cyc(); idle();
        @(negedge clk); chk("store_no_pend", busy, 0);

        // Integer-destination FPU op leaves the scoreboard alone
        cyc(); ins(1, 0, 0, 5'd9, 0, 5'd0, 5'd0, 3'b000);
        @(negedge clk); chk("fcvt_tag", fpu_tag, 0);
        cyc(); idle(); cpl(0, 5'd9, 0);
        @(negedge clk); chk("fcvt_no_wb", wb_valid, 0);
        cyc(); fpu_out_valid = 1'b0; ins(1, 0, 0, 5'd9, 1, 5'd9, 5'd0, 3'b001);
        @(negedge clk); chk("fcvt_sb_clear", in_ready, 1);
        cyc(); idle(); cpl(0, 5'd9, 1);
        cyc(); fpu_out_valid = 1'b0;

        // Fence drains outstanding ops
        ins(1, 0, 0, 5'd21, 1, 5'd0, 5'd0, 3'b000); cyc();
        ins(1, 0, 0, 5'd22, 1, 5'd0, 5'd0, 3'b000); cyc();
        idle(); fence = 1'b1;
        @(negedge clk); chk("fence_busy0", busy, 1);
        cyc(); ins(1, 0, 0, 5'd23, 1, 5'd0, 5'd0, 3'b000);
        @(negedge clk);
        chk("drain_ready", in_ready, 0);
        chk("drain_fpu_valid", fpu_valid, 0);
        cyc(); cpl(0, 5'd21, 1);
        @(negedge clk); chk("fence_busy1", busy, 1);
        cyc(); cpl(1, 5'd22, 1);
        @(negedge clk); chk("fence_busy2", busy, 1);
        cyc(); fpu_out_valid = 1'b0;
        @(negedge clk);
        chk("fence_held_busy", busy, 1);
        chk("fence_held_ready", in_ready, 0);
        cyc(); fence = 1'b0;
        @(negedge clk); chk("fence_exit_cycle", busy, 1);
        cyc();
        @(negedge clk);
        chk("run_busy", busy, 0);
        chk("run_ready", in_ready, 1);
        cyc(); idle(); cpl(0, 5'd23, 1);
        cyc(); fpu_out_valid = 1'b0;

        // Non-issuing instruction is accepted on the spot
        ins(0, 0, 0, 5'd1, 0, 5'd0, 5'd0, 3'b000);
        @(negedge clk);
        chk("other_ready", in_ready, 1);
        chk("other_fpu_valid", fpu_valid, 0);
        chk("other_mem_valid", mem_valid, 0);

        // Reset with an op outstanding; its late completion is dropped
        cyc(); ins(1, 0, 0, 5'd25, 1, 5'd0, 5'd0, 3'b000);
        cyc(); idle(); rst = 1'b1;
        @(negedge clk); chk("midrst_busy", busy, 0);
        cyc(); rst = 1'b0; cpl(0, 5'd25, 0);
        @(negedge clk); chk("late_cpl_no_wb", wb_valid, 0);
        cyc(); fpu_out_valid = 1'b0; ins(1, 0, 0, 5'd26, 1, 5'd25, 5'd0, 3'b001);
        @(negedge clk);
        chk("postrst_sb_clear", in_ready, 1);
        chk("postrst_tag", fpu_tag, 0);
        cyc(); idle(); cpl(0, 5'd26, 1);
        cyc(); fpu_out_valid = 1'b0;
        @(negedge clk);
        chk("wb_queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
